key_matrix_scanner: RTL and testbench

KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

---
 rtl/key_matrix_scanner_if.sv | 25 ++
 rtl/key_matrix_scanner.sv | 111 +++++++++++
 tb/tb_key_matrix_scanner.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_matrix_scanner_if.sv
// CPU-side register bus of the key matrix scanner: row-indexed read/clear
// port plus the pending-key interrupt.
interface key_matrix_scanner_if;
  logic [2:0]  ADDR;
  logic [15:0] DATA;
  logic        WREN;
  logic [15:0] Q;
  logic        IRQ;

  modport master (
    output ADDR,
    output DATA,
    output WREN,
    input  Q,
    input  IRQ
  );

  modport slave (
    input  ADDR,
    input  DATA,
    input  WREN,
    output Q,
    output IRQ
  );
endinterface

// File: rtl/key_matrix_scanner.sv
// 8x8 key matrix scanner: drives one row low per scan period, debounces each
// row with a two-sample agreement rule and latches new presses as pending flags.
module key_matrix_scanner #(
  parameter int unsigned SCAN_PERIOD = 50000
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  key_matrix_scanner_if.slave        bus,
  output logic [7:0]                 K_ROW,
  input  logic [7:0]                 K_COL
);

  localparam logic [15:0] LAST_COUNT = 16'(SCAN_PERIOD - 1);

  logic [7:0]  col_meta;
  logic [7:0]  col_sync;
  logic [15:0] period_cnt;
  logic [2:0]  row;

  logic [7:0]  prev_q    [8];
  logic [7:0]  stable_q  [8];
  logic [7:0]  pending_q [8];
  logic [7:0]  pending_d [8];

  logic        sample;
  logic [7:0]  raw;
  logic [7:0]  stable_nxt;
  logic [7:0]  rise;
  logic        irq_any;

  // Columns idle high, so the synchronizer resets to all ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= K_COL;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      period_cnt <= '0;
      row        <= '0;
    end else if (sample) begin
      period_cnt <= '0;
      row        <= row + 3'd1;
    end else begin
      period_cnt <= period_cnt + 16'd1;
    end
  end

  assign K_ROW = ~(8'b1 << row);

  always_comb begin
    sample     = (period_cnt == LAST_COUNT);
    raw        = ~col_sync;
    stable_nxt = (raw == prev_q[row]) ? raw : stable_q[row];
    rise       = stable_nxt & ~stable_q[row];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned r = 0; r < 8; r++) begin
        prev_q[r]   <= '0;
        stable_q[r] <= '0;
      end
    end else if (sample) begin
      prev_q[row]   <= raw;
      stable_q[row] <= stable_nxt;
    end
  end

  // Clear is applied before set so a press in the same cycle as its clear survives.
  always_comb begin
    for (int unsigned r = 0; r < 8; r++) begin
      pending_d[r] = pending_q[r];
      if (bus.WREN && (bus.ADDR == 3'(r)))
        pending_d[r] = pending_d[r] & ~bus.DATA[15:8];
      if (sample && (row == 3'(r)))
        pending_d[r] = pending_d[r] | rise;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned r = 0; r < 8; r++)
        pending_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < 8; r++)
        pending_q[r] <= pending_d[r];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      bus.Q <= '0;
    else
      bus.Q <= {pending_q[bus.ADDR], stable_q[bus.ADDR]};
  end

  always_comb begin
    irq_any = 1'b0;
    for (int unsigned r = 0; r < 8; r++)
      irq_any = irq_any | (|pending_q[r]);
  end

  assign bus.IRQ = irq_any;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner at SCAN_PERIOD=4 with a behavioural
// key matrix that pulls columns low for pressed keys on the driven row.
module tb_key_matrix_scanner;

  localparam int unsigned SP = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] k_row;
  logic [7:0] k_col;
  logic [7:0] keys [8];

  int          total;
  int          bad;
  int unsigned cyc;

  key_matrix_scanner_if bus ();

  key_matrix_scanner #(.SCAN_PERIOD(SP)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus),
    .K_ROW (k_row),
    .K_COL (k_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    k_col = '1;
    for (int r = 0; r < 8; r++)
      if (!k_row[r]) k_col = k_col & ~keys[r];
  end

  typedef struct {
    int unsigned cyc;
    logic [7:0]  krow;
  } row_vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        wren;
    logic [15:0] exp_q;
    logic        exp_irq;
  } bus_vec_t;

  row_vec_t rv [12];
  bus_vec_t bv [18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int unsigned n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    bus.WREN = 1'b0;
    bus.ADDR = 3'd0;
    bus.DATA = 16'h0000;
    for (int r = 0; r < 8; r++) keys[r] = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("reset_krow", {8'h00, k_row}, 16'h00FE);
    chk("reset_q", bus.Q, 16'h0000);
    chk("reset_irq", {15'd0, bus.IRQ}, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    logic any_irq;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b1;
    bus.ADDR = 3'd0;
    bus.DATA = 16'h0000;
    bus.WREN = 1'b0;
    for (int r = 0; r < 8; r++) keys[r] = 8'h00;

    rv[0]  = '{0,  8'hFE};
    rv[1]  = '{3,  8'hFE};
    rv[2]  = '{4,  8'hFD};
    rv[3]  = '{7,  8'hFD};
    rv[4]  = '{8,  8'hFB};
    rv[5]  = '{12, 8'hF7};
    rv[6]  = '{16, 8'hEF};
    rv[7]  = '{20, 8'hDF};
    rv[8]  = '{24, 8'hBF};
    rv[9]  = '{28, 8'h7F};
    rv[10] = '{31, 8'h7F};
    rv[11] = '{32, 8'hFE};

    bv[0]  = '{3'd2, 16'h0000, 1'b0, 16'h2020, 1'b1};
    bv[1]  = '{3'd0, 16'h0000, 1'b0, 16'h0000, 1'b1};
    bv[2]  = '{3'd1, 16'h0000, 1'b0, 16'h0000, 1'b1};
    bv[3]  = '{3'd3, 16'h0000, 1'b0, 16'h0000, 1'b1};
    bv[4]  = '{3'd4, 16'h0000, 1'b0, 16'h0000, 1'b1};
    bv[5]  = '{3'd5, 16'h0000, 1'b0, 16'h0000, 1'b1};
    bv[6]  = '{3'd6, 16'h0000, 1'b0, 16'h0000, 1'b1};
    bv[7]  = '{3'd7, 16'h0000, 1'b0, 16'h0000, 1'b1};
    bv[8]  = '{3'd2, 16'h0000, 1'b0, 16'h2020, 1'b1};
    bv[9]  = '{3'd2, 16'h0000, 1'b1, 16'h2020, 1'b1};
    bv[10] = '{3'd2, 16'h0000, 1'b0, 16'h2020, 1'b1};
    bv[11] = '{3'd3, 16'hFF00, 1'b1, 16'h0000, 1'b1};
    bv[12] = '{3'd2, 16'hDF00, 1'b1, 16'h2020, 1'b1};
    bv[13] = '{3'd2, 16'h20FF, 1'b1, 16'h2020, 1'b0};
    bv[14] = '{3'd2, 16'h0000, 1'b0, 16'h0020, 1'b0};
    bv[15] = '{3'd2, 16'h0000, 1'b0, 16'h0020, 1'b0};
    bv[16] = '{3'd2, 16'h0000, 1'b1, 16'h0020, 1'b0};
    bv[17] = '{3'd2, 16'h0000, 1'b0, 16'h0020, 1'b0};

    #2;

    // Row walk with no keys pressed.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick_to(rv[i].cyc);
      chk("row_walk", {8'h00, k_row}, {8'h00, rv[i].krow});
      chk("idle_irq", {15'd0, bus.IRQ}, 16'h0000);
    end
    chk("idle_q", bus.Q, 16'h0000);

    // Key (2,5) held: stable after second row-2 sample, then bus table.
    do_reset();
    keys[2] = 8'h20;
    tick_to(43);
    chk("held_irq_before_2nd", {15'd0, bus.IRQ}, 16'h0000);
    tick_to(44);
    chk("held_irq_after_2nd", {15'd0, bus.IRQ}, 16'h0001);
    for (int i = 0; i < 18; i++) begin
      bus.ADDR = bv[i].addr;
      bus.DATA = bv[i].data;
      bus.WREN = bv[i].wren;
      tick();
      chk("bus_q", bus.Q, bv[i].exp_q);
      chk("bus_irq", {15'd0, bus.IRQ}, {15'd0, bv[i].exp_irq});
    end
    bus.WREN = 1'b0;
    chk("row_after_writes", {8'h00, k_row}, 16'h007F);

    // Key seen in only one row-2 sample: no stable, no pending.
    do_reset();
    keys[2] = 8'h20;
    any_irq = 1'b0;
    while (cyc < 80) begin
      tick();
      if (cyc == 16) keys[2] = 8'h00;
      any_irq = any_irq | bus.IRQ;
    end
    chk("glitch_irq", {15'd0, any_irq}, 16'h0000);
    bus.ADDR = 3'd2;
    tick();
    chk("glitch_q", bus.Q, 16'h0000);

    // Clear written in the very cycle the press is latched: set wins.
    do_reset();
    keys[2] = 8'h20;
    tick_to(43);
    bus.ADDR = 3'd2;
    bus.DATA = 16'h2000;
    bus.WREN = 1'b1;
    tick();
    bus.WREN = 1'b0;
    bus.DATA = 16'h0000;
    chk("setwins_irq", {15'd0, bus.IRQ}, 16'h0001);
    tick();
    chk("setwins_q", bus.Q, 16'h2020);
    keys[2] = 8'h00;
    tick_to(107);
    chk("release_not_yet", bus.Q, 16'h2020);
    tick_to(109);
    chk("release_q", bus.Q, 16'h2000);
    chk("release_irq", {15'd0, bus.IRQ}, 16'h0001);

    // Reset mid-row-4 with keys stable and pending, then recovery.
    do_reset();
    keys[2] = 8'h20;
    keys[4] = 8'h01;
    bus.ADDR = 3'd4;
    tick_to(53);
    chk("pre_reset_q", bus.Q, 16'h0101);
    chk("pre_reset_irq", {15'd0, bus.IRQ}, 16'h0001);
    tick_to(82);
    rst_n = 1'b0;
    #1;
    chk("midrow_reset_krow", {8'h00, k_row}, 16'h00FE);
    chk("midrow_reset_q", bus.Q, 16'h0000);
    chk("midrow_reset_irq", {15'd0, bus.IRQ}, 16'h0000);
    tick();
    rst_n = 1'b1;
    cyc = 0;
    tick_to(43);
    chk("recover_irq_before", {15'd0, bus.IRQ}, 16'h0000);
    tick_to(44);
    chk("recover_irq_after", {15'd0, bus.IRQ}, 16'h0001);
    tick_to(52);
    chk("recover_q_before", bus.Q, 16'h0000);
    tick_to(53);
    chk("recover_q_after", bus.Q, 16'h0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
